line_merge_seq: RTL and testbench
=================================

LINE_MERGE_SEQ -- requirements
Module: line_merge_seq

Interface
REQ-001 SHALL have parameter N, default 4: tiles per line, range 2..16.
REQ-002 SHALL have parameter W, default 4: tile exponent width in bits; value 0 means an empty cell.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: a line is offered.
REQ-006 SHALL have port in_ready, output, 1: the block accepts a line.
REQ-007 SHALL have port in_line, input, N*W: tile k in bits [k*W +: W]; tile 0 is the destination end.
REQ-008 SHALL have port out_valid, output, 1: a result is held.
REQ-009 SHALL have port out_ready, input, 1: the consumer takes the result.
REQ-010 SHALL have port out_line, output, N*W: the merged and compacted line.
REQ-011 SHALL have port out_moved, output, 1: out_line differs from the accepted in_line.
REQ-012 SHALL have port out_merges, output, clog2(N)+1: number of merges performed.

Function
REQ-013 SHALL use a four-state FSM.
- IDLE -> SCAN on the in handshake.
- SCAN -> FLUSH after N scan cycles.
- FLUSH -> DONE after one cycle.
- DONE -> IDLE on the out handshake.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 On accept, the block SHALL register in_line and clear the scan index, write index, pending tile, merge count and score.
REQ-016 SCAN SHALL examine one tile per cycle, index 0 to N-1.
- Zero tile: skip it.
- No pending tile: the tile becomes pending.
- Pending equal to tile and below 2^W-1: write pending+1 at the write index, advance the write index, clear pending, increment merges.
- Otherwise: write pending at the write index, advance the write index, the tile becomes pending.
REQ-017 A merged result SHALL never merge again within the same line.
REQ-018 Tiles of value 2^W-1 SHALL never merge: they saturate, with no wrap to 0.
REQ-019 FLUSH SHALL write any pending tile at the write index; all unwritten output cells SHALL be 0.
REQ-020 Latency: if the in handshake occurs at edge T, out_valid SHALL rise after edge T+N+2.
REQ-021 out_line, out_moved, out_merges and out_score SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 in_valid SHALL be ignored outside IDLE; there is no simultaneous accept and release.
REQ-023 out_moved SHALL be computed in FLUSH by comparing the final line against the registered input.

Reset
REQ-024 While rst=1, the block SHALL enter IDLE; in_ready=1 (from the next cycle); out_valid=0; out_line=0, out_moved=0, out_merges=0, out_score=0.
REQ-025 Reset during SCAN, FLUSH or DONE SHALL discard the line in progress with no partial output.

Configuration
REQ-026 With LINE_MERGE_SCORE_EN defined, the block SHALL add port out_score, output, 2**W+clog2(N) bits, holding the sum of 2^v over every merged result v.
REQ-027 Without LINE_MERGE_SCORE_EN, the block SHALL have neither the out_score port nor the score logic; all other behaviour is identical.

Structure
REQ-028 Package line_merge_pkg SHALL hold:
- the FSM state enum (IDLE, SCAN, FLUSH, DONE);
- the default N and W constants;
- a function returning the saturation value 2^W-1.
REQ-029 Sub-module merge_step (combinational) SHALL decide one tile step: inputs pending and tile; outputs write enable, write value, next pending, merge flag.

Verification (N=4, W=4; lines written {t3,t2,t1,t0} in hex)
REQ-030 {1,1,1,1} -> {0,0,2,2}; merges=2; score=8; moved=1; out_valid 6 cycles after accept.
REQ-031 {2,2,2,0} -> {0,0,2,3}; merges=1; score=8. {0,2,0,2} -> {0,0,0,3}; score=8; moved=1.
REQ-032 {4,3,2,1} -> {4,3,2,1}; merges=0; score=0; moved=0.
REQ-033 {F,F,0,0} -> {0,0,F,F}; merges=0; moved=1 (saturation, no wrap).
REQ-034 Hold out_ready=0 for 3 cycles in DONE -> outputs stable, in_ready=0. Then the out handshake -> in_ready=1 next cycle, and a second line is accepted.
REQ-035 Assert rst during the third SCAN cycle -> next cycle IDLE: in_ready=1, out_valid=0, all outputs 0. A following line {0,0,1,1} yields {0,0,0,2}.

Source files
------------

// File: rtl/line_merge_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | line_merge_pkg : shared types and constants for the line merge engine    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package line_merge_pkg;

    localparam int N_DEFAULT = 4;
    localparam int W_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Largest tile exponent representable in w bits; such tiles never merge.
    function automatic int sat_val(input int w);
        return (1 << w) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_merge_seq_merge_step.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | merge_step : combinational decision for one tile of the merge scan       |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module merge_step
    import line_merge_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         pend_valid_i,
    input  logic [W-1:0] pend_i,
    input  logic [W-1:0] tile_i,
    output logic         wr_en_o,
    output logic [W-1:0] wr_val_o,
    output logic         nxt_valid_o,
    output logic [W-1:0] nxt_pend_o,
    output logic         merge_o
);

    localparam logic [W-1:0] c_SAT = W'(sat_val(W));

    always_comb begin
        wr_en_o     = 1'b0;
        wr_val_o    = pend_i;
        nxt_valid_o = pend_valid_i;
        nxt_pend_o  = pend_i;
        merge_o     = 1'b0;
        if (tile_i != '0) begin
            if (!pend_valid_i) begin
                nxt_valid_o = 1'b1;
                nxt_pend_o  = tile_i;
            end else if ((pend_i == tile_i) && (pend_i != c_SAT)) begin
                // The merged value is written out immediately, so it can never
                // be picked up again as a pending tile.
                wr_en_o     = 1'b1;
                wr_val_o    = pend_i + 1'b1;
                nxt_valid_o = 1'b0;
                nxt_pend_o  = '0;
                merge_o     = 1'b1;
            end else begin
                wr_en_o     = 1'b1;
                wr_val_o    = pend_i;
                nxt_pend_o  = tile_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/line_merge_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | line_merge_seq : sequential merge/compact of one tile line toward tile 0 |
// | Optional macro LINE_MERGE_SCORE_EN adds the out_score port and logic.    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module line_merge_seq
    import line_merge_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int W = W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N*W-1:0]         in_line,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N*W-1:0]         out_line,
    output logic                   out_moved,
    output logic [$clog2(N):0]     out_merges
`ifdef LINE_MERGE_SCORE_EN
    ,
    output logic [2**W+$clog2(N)-1:0] out_score
`endif
);

    localparam int c_IW = $clog2(N);
    localparam int c_CW = c_IW + 1;
    localparam logic [c_CW-1:0] c_IDX_END = c_CW'(N);

    state_e state_q, state_d;

    logic [W-1:0]    in_q   [N];
    logic [W-1:0]    res_q  [N];
    logic [c_CW-1:0] idx_q;
    logic [c_CW-1:0] wr_q;
    logic            pend_v_q;
    logic [W-1:0]    pend_q;
    logic [c_CW-1:0] merges_q;

    logic [N*W-1:0]  out_line_q;
    logic            out_moved_q;
    logic [c_CW-1:0] out_merges_q;

`ifdef LINE_MERGE_SCORE_EN
    localparam int c_SW = 2**W + c_IW;
    logic [c_SW-1:0] score_q;
    logic [c_SW-1:0] out_score_q;
`endif

    logic            w_scan_act;
    logic [W-1:0]    w_tile;
    logic            w_wr_en;
    logic [W-1:0]    w_wr_val;
    logic            w_nxt_pv;
    logic [W-1:0]    w_nxt_p;
    logic            w_merge;
    logic [N*W-1:0]  w_in_packed;
    logic [N*W-1:0]  w_final;

    // SCAN walks tiles 0..N-1, then spends one cycle at index N before FLUSH.
    assign w_scan_act = (state_q == ST_SCAN) && (idx_q != c_IDX_END);
    assign w_tile     = in_q[idx_q[c_IW-1:0]];

    merge_step #(
        .W(W)
    ) u_step (
        .pend_valid_i (pend_v_q),
        .pend_i       (pend_q),
        .tile_i       (w_tile),
        .wr_en_o      (w_wr_en),
        .wr_val_o     (w_wr_val),
        .nxt_valid_o  (w_nxt_pv),
        .nxt_pend_o   (w_nxt_p),
        .merge_o      (w_merge)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (idx_q == c_IDX_END) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Final line is the written cells plus any pending tile at the write index.
    always_comb begin
        w_in_packed = '0;
        w_final     = '0;
        for (int k = 0; k < N; k++) begin
            w_in_packed[k*W +: W] = in_q[k];
            w_final[k*W +: W]     = res_q[k];
            if (pend_v_q && (wr_q == c_CW'(k))) begin
                w_final[k*W +: W] = pend_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                in_q[k]  <= '0;
                res_q[k] <= '0;
            end
            idx_q        <= '0;
            wr_q         <= '0;
            pend_v_q     <= 1'b0;
            pend_q       <= '0;
            merges_q     <= '0;
            out_line_q   <= '0;
            out_moved_q  <= 1'b0;
            out_merges_q <= '0;
`ifdef LINE_MERGE_SCORE_EN
            score_q      <= '0;
            out_score_q  <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        for (int k = 0; k < N; k++) begin
                            in_q[k]  <= in_line[k*W +: W];
                            res_q[k] <= '0;
                        end
                        idx_q    <= '0;
                        wr_q     <= '0;
                        pend_v_q <= 1'b0;
                        pend_q   <= '0;
                        merges_q <= '0;
`ifdef LINE_MERGE_SCORE_EN
                        score_q  <= '0;
`endif
                    end
                end
                ST_SCAN: begin
                    if (w_scan_act) begin
                        idx_q    <= idx_q + 1'b1;
                        pend_v_q <= w_nxt_pv;
                        pend_q   <= w_nxt_p;
                        if (w_wr_en) begin
                            res_q[wr_q[c_IW-1:0]] <= w_wr_val;
                            wr_q                  <= wr_q + 1'b1;
                        end
                        if (w_merge) begin
                            merges_q <= merges_q + 1'b1;
`ifdef LINE_MERGE_SCORE_EN
                            score_q  <= score_q + (c_SW'(1) << w_wr_val);
`endif
                        end
                    end
                end
                ST_FLUSH: begin
                    out_line_q   <= w_final;
                    out_moved_q  <= (w_final != w_in_packed);
                    out_merges_q <= merges_q;
`ifdef LINE_MERGE_SCORE_EN
                    out_score_q  <= score_q;
`endif
                end
                default: begin
                end
            endcase
        end
    end

    assign out_line   = out_line_q;
    assign out_moved  = out_moved_q;
    assign out_merges = out_merges_q;
`ifdef LINE_MERGE_SCORE_EN
    assign out_score  = out_score_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_line_merge_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_line_merge_seq : directed and random checks of line_merge_seq (N=4)   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_line_merge_seq;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int NW = N * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [NW-1:0] in_line;
    logic          out_valid;
    logic          out_ready;
    logic [NW-1:0] out_line;
    logic          out_moved;
    logic [2:0]    out_merges;
`ifdef LINE_MERGE_SCORE_EN
    logic [17:0]   out_score;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    line_merge_seq #(
        .N(N),
        .W(W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_line    (in_line),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_line   (out_line),
        .out_moved  (out_moved),
        .out_merges (out_merges)
`ifdef LINE_MERGE_SCORE_EN
        ,
        .out_score  (out_score)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: drop empty cells, then pair equal neighbours left to right.
    function automatic void model(input logic [NW-1:0] l, output logic [NW-1:0] o,
                                  output int m, output longint s);
        int a[$];
        int r[$];
        int i;
        a = {};
        r = {};
        m = 0;
        s = 0;
        for (int k = 0; k < N; k++) begin
            if (l[k*W +: W] != '0) a.push_back(int'(l[k*W +: W]));
        end
        i = 0;
        while (i < a.size()) begin
            if ((i + 1 < a.size()) && (a[i] == a[i+1]) && (a[i] != 15)) begin
                r.push_back(a[i] + 1);
                m++;
                s += longint'(1) << (a[i] + 1);
                i += 2;
            end else begin
                r.push_back(a[i]);
                i += 1;
            end
        end
        o = '0;
        for (int k = 0; k < r.size(); k++) o[k*W +: W] = 4'(r[k]);
    endfunction

    task automatic check_result(input string tag, input logic [NW-1:0] el, input int em,
                                input logic em_moved, input longint es);
        chk({tag, ".line"}, 64'(out_line), 64'(el));
        chk({tag, ".merges"}, 64'(out_merges), 64'(em));
        chk({tag, ".moved"}, 64'(out_moved), 64'(em_moved));
`ifdef LINE_MERGE_SCORE_EN
        chk({tag, ".score"}, 64'(out_score), 64'(es));
`else
        if (es < 0) $display("unexpected negative score");
`endif
    endtask

    task automatic run_line(input string tag, input logic [NW-1:0] line, input int hold);
        logic [NW-1:0] el;
        int            em;
        longint        es;
        int            cyc;
        model(line, el, em, es);
        cyc = 0;
        while (in_ready !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk({tag, ".ready"}, 64'(in_ready), 64'd1);
        in_line  = line;
        in_valid = 1'b1;
        tick();
        // Keep offering junk while busy; it must be ignored.
        in_line = NW'($urandom);
        chk({tag, ".busy_ready"}, 64'(in_ready), 64'd0);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        chk({tag, ".latency"}, 64'(cyc), 64'(N + 2));
        check_result(tag, el, em, (el != line), es);
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            tick();
            chk({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
            chk({tag, ".hold_ready"}, 64'(in_ready), 64'd0);
            check_result({tag, ".hold"}, el, em, (el != line), es);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, ".release_ready"}, 64'(in_ready), 64'd1);
        chk({tag, ".release_valid"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [NW-1:0] rl;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_line   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.out_line", 64'(out_line), 64'd0);
        chk("rst.moved", 64'(out_moved), 64'd0);
        chk("rst.merges", 64'(out_merges), 64'd0);
        rst = 1'b0;
        tick();

        run_line("ones", 16'h1111, 0);
        chk("ones.const", 64'(out_line), 64'h0022);
        run_line("twos", 16'h2220, 1);
        run_line("gaps", 16'h0202, 0);
        run_line("distinct", 16'h4321, 0);
        run_line("sat", 16'hFF00, 3);
        chk("sat.const", 64'(out_line), 64'h00FF);
        run_line("second", 16'h0303, 0);

        // Reset in the third SCAN cycle discards the line.
        in_line  = 16'h1111;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst.in_ready", 64'(in_ready), 64'd1);
        chk("mrst.out_valid", 64'(out_valid), 64'd0);
        chk("mrst.out_line", 64'(out_line), 64'd0);
        chk("mrst.moved", 64'(out_moved), 64'd0);
        chk("mrst.merges", 64'(out_merges), 64'd0);
        run_line("after_rst", 16'h0011, 0);
        chk("after_rst.const", 64'(out_line), 64'h0002);

        for (int t = 0; t < 24; t++) begin
            rl = '0;
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 7) == 0) rl[k*W +: W] = 4'hF;
                else rl[k*W +: W] = 4'($urandom_range(0, 3));
            end
            run_line("rand", rl, int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
